chacha20_block_ctrl: RTL and testbench

Sequencer that runs a full ChaCha20 block function (RFC 7539 §2.3) on a single shared `chacha20_qr` quarter-round datapath. It holds the 16-word input state and a 16-word working state, and issues one quarter-round per cycle in column/diagonal order for `ROUNDS` rounds. It then performs the feed-forward addition one word per cycle and exposes the result through a word-addressed read port. It sits between the pin-level load/readout logic and the quarter-round datapath.

---
 rtl/chacha20_pkg.sv | 26 ++
 rtl/chacha20_qr.sv | 28 ++
 rtl/chacha20_block_ctrl.sv | 146 ++++++++++++++
 tb/tb_chacha20_block_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/chacha20_pkg.sv
// Shared definitions for the ChaCha20 block sequencer: sigma constants, FSM states,
// the quarter-round word-group table and a 32-bit rotate helper.
package chacha20_pkg;

    localparam logic [31:0] SIGMA [4] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    // Each entry packs the {a,b,c,d} word indices, a in the top nibble.
    // Entries 0..3 are the columns, 4..7 the diagonals.
    localparam logic [15:0] QR_IDX [8] = '{
        16'h048C, 16'h159D, 16'h26AE, 16'h37BF,
        16'h05AF, 16'h16BC, 16'h278D, 16'h349E
    };

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        rotl32 = (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha20_qr.sv
// Combinational ChaCha20 quarter-round: the only add/xor/rotate datapath of the block.
module chacha20_qr (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] a2,
    output logic [31:0] b2,
    output logic [31:0] c2,
    output logic [31:0] d2
);
    import chacha20_pkg::*;

    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] c1;
    logic [31:0] d1;

    assign a1 = a + b;
    assign d1 = rotl32(d ^ a1, 16);
    assign c1 = c + d1;
    assign b1 = rotl32(b ^ c1, 12);
    assign a2 = a1 + b1;
    assign d2 = rotl32(d1 ^ a2, 8);
    assign c2 = c1 + d2;
    assign b2 = rotl32(b1 ^ c2, 7);

endmodule

// File: rtl/chacha20_block_ctrl.sv
// ChaCha20 block sequencer: one quarter-round per cycle on a shared datapath,
// then a word-serial feed-forward add, with a combinational word read port.
module chacha20_block_ctrl #(
    parameter int ROUNDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic        start,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);
    import chacha20_pkg::*;

    // Handshake: load/start are single-cycle requests sampled on the rising edge and
    // honoured only while busy is low; done is a one-cycle pulse in the first idle cycle.

    localparam int QC_N = ROUNDS * 4;
    localparam int QC_W = $clog2(QC_N);
    localparam logic [QC_W-1:0] QC_LAST = QC_W'(QC_N - 1);

    state_t state;
    state_t state_nxt;

    logic [QC_W-1:0] qc;
    logic [3:0]      wc;
    logic [31:0]     init_w [16];
    logic [31:0]     work   [16];

    logic [15:0] sel;
    logic [3:0]  ia;
    logic [3:0]  ib;
    logic [3:0]  ic;
    logic [3:0]  id;
    logic [31:0] a_new;
    logic [31:0] b_new;
    logic [31:0] c_new;
    logic [31:0] d_new;

    assign sel = QR_IDX[qc[2:0]];
    assign ia  = sel[15:12];
    assign ib  = sel[11:8];
    assign ic  = sel[7:4];
    assign id  = sel[3:0];

    chacha20_qr u_qr (
        .a  (work[ia]),
        .b  (work[ib]),
        .c  (work[ic]),
        .d  (work[id]),
        .a2 (a_new),
        .b2 (b_new),
        .c2 (c_new),
        .d2 (d_new)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (qc == QC_LAST) begin
                    state_nxt = FINAL;
                end
            end
            FINAL: begin
                busy = 1'b1;
                if (wc == 4'd15) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qc   <= '0;
            wc   <= '0;
            done <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                init_w[i] <= '0;
                work[i]   <= '0;
            end
        end else begin
            done <= (state == FINAL) && (wc == 4'd15);
            case (state)
                IDLE: begin
                    // start takes priority: a simultaneous load is dropped
                    if (start) begin
                        for (int i = 0; i < 16; i++) begin
                            work[i] <= init_w[i];
                        end
                        qc <= '0;
                        wc <= '0;
                    end else if (load) begin
                        init_w[addr] <= wdata;
                    end
                end
                ROUND: begin
                    work[ia] <= a_new;
                    work[ib] <= b_new;
                    work[ic] <= c_new;
                    work[id] <= d_new;
                    if (qc == QC_LAST) begin
                        qc <= '0;
                        wc <= '0;
                    end else begin
                        qc <= qc + 1'b1;
                    end
                end
                FINAL: begin
                    work[wc] <= work[wc] + init_w[wc];
                    wc       <= wc + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata     = work[raddr];
    assign dbg_state = state;

endmodule

// File: tb/tb_chacha20_block_ctrl.sv
// Directed bench for chacha20_block_ctrl: RFC block vector, zero state, ignored
// requests while busy, back-to-back start, mid-run reset and a ROUNDS=2 instance.
module tb_chacha20_block_ctrl;
    import chacha20_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        start;
    logic [3:0]  addr;
    logic [3:0]  raddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] rdata2;
    logic        busy;
    logic        busy2;
    logic        done;
    logic        done2;
    logic [1:0]  st;
    logic [1:0]  st2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_init [16];
    logic [31:0] m_x    [16];
    logic [31:0] m_out  [16];
    logic [31:0] exp_q  [$];

    typedef struct {
        logic [3:0]  raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t rfc_vec [3];
    vec_t qr_vec  [4];

    logic [31:0] rfc_init [16];

    always #5 clk = ~clk;

    chacha20_block_ctrl #(.ROUNDS(20)) dut (
        .clk (clk), .reset (reset), .load (load), .addr (addr), .wdata (wdata),
        .start (start), .raddr (raddr), .rdata (rdata), .busy (busy), .done (done),
        .dbg_state (st)
    );

    chacha20_block_ctrl #(.ROUNDS(2)) dut2 (
        .clk (clk), .reset (reset), .load (load), .addr (addr), .wdata (wdata),
        .start (start), .raddr (raddr), .rdata (rdata2), .busy (busy2), .done (done2),
        .dbg_state (st2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tb_rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic mqr(input int a, input int b, input int c, input int d);
        m_x[a] = m_x[a] + m_x[b]; m_x[d] = tb_rotl(m_x[d] ^ m_x[a], 16);
        m_x[c] = m_x[c] + m_x[d]; m_x[b] = tb_rotl(m_x[b] ^ m_x[c], 12);
        m_x[a] = m_x[a] + m_x[b]; m_x[d] = tb_rotl(m_x[d] ^ m_x[a], 8);
        m_x[c] = m_x[c] + m_x[d]; m_x[b] = tb_rotl(m_x[b] ^ m_x[c], 7);
    endtask

    // Reference ChaCha block function over m_init, including feed-forward.
    task automatic model(input int rounds);
        for (int i = 0; i < 16; i++) m_x[i] = m_init[i];
        for (int r = 0; r < rounds / 2; r++) begin
            mqr(0, 4, 8, 12); mqr(1, 5, 9, 13); mqr(2, 6, 10, 14); mqr(3, 7, 11, 15);
            mqr(0, 5, 10, 15); mqr(1, 6, 11, 12); mqr(2, 7, 8, 13); mqr(3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) m_out[i] = m_x[i] + m_init[i];
    endtask

    task automatic load_word(input logic [3:0] a, input logic [31:0] d);
        load  = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk); #1;
        load  = 1'b0;
        m_init[a] = d;
    endtask

    task automatic read_word(input bit sel2, input logic [3:0] a, output logic [31:0] v);
        raddr = a;
        #1;
        v = sel2 ? rdata2 : rdata;
    endtask

    // Pulses start, then counts edges until done. Cycle numbering: start sampled at
    // edge T, done visible in cycle T+ROUNDS*4+17, i.e. after edge T+ROUNDS*4+16.
    task automatic run_block(input bit sel2, input int exp_edges, input bit inject,
                             input bit peek, input string name);
        int          n;
        logic        d;
        logic [31:0] v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy"}, {31'b0, (sel2 ? busy2 : busy)}, 32'd1);
        n = 0;
        d = 1'b0;
        while (!d && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (inject && n == 10) begin
                load = 1'b1; addr = 4'd0; wdata = 32'hdeadbeef; start = 1'b1;
            end
            if (inject && n == 11) begin
                load = 1'b0; start = 1'b0;
            end
            if (peek && n == 1) begin
                for (int i = 0; i < 4; i++) begin
                    read_word(1'b1, qr_vec[i].raddr, v);
                    check(qr_vec[i].name, v, qr_vec[i].exp);
                end
            end
            d = sel2 ? done2 : done;
        end
        check({name, " done latency"}, n, exp_edges);
    endtask

    task automatic compare_all(input bit sel2, input int rounds, input string name);
        logic [31:0] v;
        model(rounds);
        for (int i = 0; i < 16; i++) exp_q.push_back(m_out[i]);
        for (int i = 0; i < 16; i++) begin
            read_word(sel2, 4'(i), v);
            check($sformatf("%s w%0d", name, i), v, exp_q.pop_front());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string name);
        logic [31:0] v;
        check({name, " busy"}, {31'b0, busy}, 32'd0);
        check({name, " done"}, {31'b0, done}, 32'd0);
        check({name, " state"}, {30'b0, st}, {30'b0, IDLE});
        check({name, " busy2"}, {31'b0, busy2}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            read_word(1'b0, 4'(i), v);
            check($sformatf("%s rdata%0d", name, i), v, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] v;
        rfc_vec[0] = '{4'd0,  32'he4e7f110, "rfc w0 const"};
        rfc_vec[1] = '{4'd1,  32'h15593bd1, "rfc w1 const"};
        rfc_vec[2] = '{4'd15, 32'h4e3c50a2, "rfc w15 const"};
        qr_vec[0]  = '{4'd0,  32'hea2a92f4, "qr col0 a"};
        qr_vec[1]  = '{4'd4,  32'hcb1cf8ce, "qr col0 b"};
        qr_vec[2]  = '{4'd8,  32'h4581472e, "qr col0 c"};
        qr_vec[3]  = '{4'd12, 32'h5881c4bb, "qr col0 d"};
        rfc_init = '{SIGMA[0], SIGMA[1], SIGMA[2], SIGMA[3],
                     32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                     32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                     32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        for (int i = 0; i < 16; i++) m_init[i] = '0;

        reset = 1'b1; load = 1'b0; start = 1'b0;
        addr = '0; wdata = '0; raddr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_reset_values("reset");
        @(posedge clk); #1;

        // RFC 7539 block vector
        for (int i = 0; i < 16; i++) load_word(4'(i), rfc_init[i]);
        run_block(1'b0, 96, 1'b0, 1'b0, "rfc");
        for (int k = 0; k < 3; k++) begin
            read_word(1'b0, rfc_vec[k].raddr, v);
            check(rfc_vec[k].name, v, rfc_vec[k].exp);
        end
        @(posedge clk); #1;
        compare_all(1'b0, 20, "rfc");

        // Back-to-back start in the done cycle, with load/start pulsed while busy
        run_block(1'b0, 96, 1'b0, 1'b0, "rerun");
        run_block(1'b0, 96, 1'b1, 1'b0, "b2b");
        compare_all(1'b0, 20, "b2b");

        // Mid-ROUND reset aborts to reset values
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset_values("midreset");
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 16; i++) m_init[i] = '0;
        @(posedge clk); #1;

        // All-zero state after reset
        run_block(1'b0, 96, 1'b0, 1'b0, "zero");
        for (int i = 0; i < 16; i++) begin
            read_word(1'b0, 4'(i), v);
            check($sformatf("zero w%0d", i), v, 32'd0);
        end
        @(posedge clk); #1;

        // ROUNDS=2 instance: first column QR visible right after its write, then full result
        for (int i = 0; i < 16; i++) load_word(4'(i), 32'(i) * 32'h01010101 + 32'h10203040);
        load_word(4'd0,  32'h11111111);
        load_word(4'd4,  32'h01020304);
        load_word(4'd8,  32'h9b8d6f43);
        load_word(4'd12, 32'h01234567);
        run_block(1'b1, 24, 1'b0, 1'b1, "r2");
        compare_all(1'b1, 2, "r2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
